// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit between NREQ requesters.
// Optional per-requester grant counters when LOGIC_ARB_STATS_EN is defined.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  localparam int IDW = (NREQ > 2) ? 2 : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_z,
  input  logic                    rsp_ready,
`ifdef LOGIC_ARB_STATS_EN
  output logic [16*NREQ-1:0]      grant_cnt,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [2*NREQ-1:0] rot;
  logic [IDW:0]      sum;
  logic              gnt_found;
  logic [IDW-1:0]    gnt_idx;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  lu_z;
  logic [IDW-1:0]    rr_nxt;

  // Find the first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    rot       = {req_valid, req_valid} >> rr_ptr;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && rot[k]) begin
        gnt_found = 1'b1;
        sum = {1'b0, rr_ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        gnt_idx = sum[IDW-1:0];
      end
    end
  end

  // Route the granted requester's op and operands, and drive the one-hot accept.
  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_op = req_op[2*k +: 2];
        sel_a  = req_a[WIDTH*k +: WIDTH];
        sel_b  = req_b[WIDTH*k +: WIDTH];
      end
    end
    if (state == IDLE && gnt_found && !rst)
      req_ready = NREQ'(1) << gnt_idx;
  end

  // The shared bitwise logic unit operating on the latched operation.
  always_comb begin
    lu_z = '0;
    unique case (op_q)
      2'b00: lu_z = a_q & b_q;
      2'b01: lu_z = a_q | b_q;
      2'b10: lu_z = a_q ^ b_q;
      2'b11: lu_z = ~(a_q | b_q);
    endcase
  end

  assign rr_nxt = (gnt_q == IDW'(NREQ-1)) ? '0 : gnt_q + 1'b1;
  assign busy   = (state != IDLE);

  // Accept, execute, then hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_q <= gnt_idx;
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_z     <= lu_z;
          rsp_id    <= gnt_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rr_nxt;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  // Saturating accept counters, one per requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k] && grant_cnt[16*k +: 16] != 16'hFFFF)
          grant_cnt[16*k +: 16] <= grant_cnt[16*k +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
